// File: rtl/handshake_pkg.sv
// Shared constants and FSM encoding for the bus requester slice.
// States are plain 2-bit constants so legacy code can compare them directly.
package handshake_pkg;
  localparam int DATA_W    = 64;
  localparam int TIMEOUT_W = 8;

  typedef logic [1:0] req_state_t;

  localparam req_state_t IDLE    = 2'd0;
  localparam req_state_t REQ     = 2'd1;
  localparam req_state_t XFER    = 2'd2;
  localparam req_state_t BACKOFF = 2'd3;
endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO; head word visible combinationally on rdata_o.
// Pointers carry an extra wrap bit; full is independent of a same-cycle pop.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/bus_requester.sv
// Shared-bus initiator: buffers local words, requests the bus, bursts on grant.
// Request is dropped for at least one cycle between requests; back-off after MAX_WAIT.
module bus_requester
  import handshake_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BURST_LEN  = 4,
  parameter int MAX_WAIT   = 15
) (
  input  logic                 clkA,
  input  logic                 reset,
  input  logic                 wr_valid,
  input  logic [DATA_W-1:0]    wr_data,
  output logic                 wr_ready,
  input  logic                 gntA,
  output logic                 reqA,
  output logic [DATA_W-1:0]    sharedBus,
  output logic                 bus_valid,
  output logic                 busy,
  output logic [TIMEOUT_W-1:0] timeout_cnt
);
  localparam int WAIT_W = $clog2(MAX_WAIT);
  localparam int BEAT_W = $clog2(BURST_LEN + 1);

  req_state_t           state_q, state_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
  logic [DATA_W-1:0]    bus_q, bus_d;
  logic                 valid_q, valid_d;
  logic                 req_q, req_d;

  logic              fifo_full, fifo_empty, fifo_pop;
  logic [DATA_W-1:0] fifo_head;

  assign wr_ready = !fifo_full;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clkA),
    .rst_i   (reset),
    .push_i  (wr_valid && wr_ready),
    .pop_i   (fifo_pop),
    .wdata_i (wr_data),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    beat_cnt_d = beat_cnt_q;
    timeout_d  = timeout_q;
    bus_d      = '0;
    valid_d    = 1'b0;
    fifo_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        wait_cnt_d = '0;
        beat_cnt_d = '0;
        if (!fifo_empty) state_d = REQ;
      end
      REQ: begin
        // A grant on the timeout cycle still wins.
        if (gntA) begin
          state_d    = XFER;
          beat_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_W'(MAX_WAIT - 1)) begin
          state_d = BACKOFF;
          if (timeout_q != {TIMEOUT_W{1'b1}}) timeout_d = timeout_q + 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      XFER: begin
        if (!fifo_empty && (beat_cnt_q < BEAT_W'(BURST_LEN))) begin
          fifo_pop   = 1'b1;
          bus_d      = fifo_head;
          valid_d    = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d    = REQ;
        wait_cnt_d = '0;
      end
    endcase
    req_d = (state_d == REQ);
  end

  always_ff @(posedge clkA) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      beat_cnt_q <= '0;
      timeout_q  <= '0;
      bus_q      <= '0;
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      timeout_q  <= timeout_d;
      bus_q      <= bus_d;
      valid_q    <= valid_d;
      req_q      <= req_d;
    end
  end

  assign reqA        = req_q;
  assign sharedBus   = bus_q;
  assign bus_valid   = valid_q;
  assign timeout_cnt = timeout_q;
  assign busy        = (state_q != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_bus_requester.sv
// Directed bench for bus_requester: reset, bursts, burst split, timeout, full FIFO, mid-burst reset.
module tb_bus_requester;
  logic        clkA = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic [63:0] wr_data;
  logic        wr_ready;
  logic        gntA;
  logic        reqA;
  logic [63:0] sharedBus;
  logic        bus_valid;
  logic        busy;
  logic [7:0]  timeout_cnt;

  int checks = 0;
  int errors = 0;

  bus_requester dut (
    .clkA        (clkA),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .gntA        (gntA),
    .reqA        (reqA),
    .sharedBus   (sharedBus),
    .bus_valid   (bus_valid),
    .busy        (busy),
    .timeout_cnt (timeout_cnt)
  );

  always #5 clkA = ~clkA;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clkA);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [63:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic grant();
    gntA = 1'b1;
    step();
    gntA = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [63:0] d);
    step();
    chk({tag, "_vld"}, {63'd0, bus_valid}, 64'd1);
    chk({tag, "_dat"}, sharedBus, d);
  endtask

  task automatic burst_end(input string tag);
    step();
    chk({tag, "_vld0"}, {63'd0, bus_valid}, 64'd0);
    chk({tag, "_bus0"}, sharedBus, 64'd0);
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    gntA     = 1'b0;

    // 1: reset
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_req",   {63'd0, reqA},      64'd0);
    chk("rst_vld",   {63'd0, bus_valid}, 64'd0);
    chk("rst_bus",   sharedBus,          64'd0);
    chk("rst_tmo",   {56'd0, timeout_cnt}, 64'd0);
    chk("rst_busy",  {63'd0, busy},      64'd0);
    chk("rst_wrrdy", {63'd0, wr_ready},  64'd1);

    // 2: two-word burst, grant 3 cycles after request
    push(64'hA);
    chk("t2_busy", {63'd0, busy}, 64'd1);
    push(64'hB);
    chk("t2_req_rise", {63'd0, reqA}, 64'd1);
    step(); step();
    chk("t2_req_hold", {63'd0, reqA}, 64'd1);
    grant();
    chk("t2_req_fall", {63'd0, reqA}, 64'd0);
    chk("t2_no_beat_yet", {63'd0, bus_valid}, 64'd0);
    beat("t2_b0", 64'hA);
    beat("t2_b1", 64'hB);
    burst_end("t2_end");
    chk("t2_idle_busy", {63'd0, busy}, 64'd0);

    // 3: six words, burst capped at four; words pushed mid-burst join the queue
    push(64'h100); push(64'h101); push(64'h102); push(64'h103);
    chk("t3_full", {63'd0, wr_ready}, 64'd0);
    chk("t3_req", {63'd0, reqA}, 64'd1);
    grant();
    beat("t3_w0", 64'h100);
    wr_valid = 1'b1; wr_data = 64'h104;
    beat("t3_w1", 64'h101);
    wr_data = 64'h105;
    beat("t3_w2", 64'h102);
    wr_valid = 1'b0;
    beat("t3_w3", 64'h103);
    burst_end("t3_end1");
    chk("t3_req_gap", {63'd0, reqA}, 64'd0);
    step();
    chk("t3_rereq", {63'd0, reqA}, 64'd1);
    grant();
    beat("t3_w4", 64'h104);
    beat("t3_w5", 64'h105);
    burst_end("t3_end2");

    // 4: no grant -> 15 cycles of request, one cycle back-off, re-request
    push(64'hC0FFEE);
    step();
    chk("t4_req_rise", {63'd0, reqA}, 64'd1);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!reqA) break;
      n++;
    end
    chk("t4_req_len", 64'(n), 64'd15);
    chk("t4_backoff_req", {63'd0, reqA}, 64'd0);
    chk("t4_tmo", {56'd0, timeout_cnt}, 64'd1);
    step();
    chk("t4_rereq", {63'd0, reqA}, 64'd1);
    grant();
    beat("t4_word", 64'hC0FFEE);
    burst_end("t4_end");

    // 5: full FIFO refuses a 5th word, including on the first pop cycle
    push(64'h200); push(64'h201); push(64'h202); push(64'h203);
    chk("t5_wrrdy0", {63'd0, wr_ready}, 64'd0);
    wr_valid = 1'b1; wr_data = 64'h2FF;
    step();
    chk("t5_wrrdy_hold", {63'd0, wr_ready}, 64'd0);
    grant();
    beat("t5_w0", 64'h200);
    wr_valid = 1'b0;
    beat("t5_w1", 64'h201);
    beat("t5_w2", 64'h202);
    beat("t5_w3", 64'h203);
    burst_end("t5_end");
    chk("t5_no_extra", {63'd0, busy}, 64'd0);

    // 6: reset after beat 2 of a 4-beat burst
    push(64'h300); push(64'h301); push(64'h302); push(64'h303);
    grant();
    beat("t6_w0", 64'h300);
    beat("t6_w1", 64'h301);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_vld", {63'd0, bus_valid}, 64'd0);
    chk("t6_req", {63'd0, reqA}, 64'd0);
    chk("t6_bus", sharedBus, 64'd0);
    chk("t6_busy", {63'd0, busy}, 64'd0);
    chk("t6_tmo", {56'd0, timeout_cnt}, 64'd0);
    chk("t6_wrrdy", {63'd0, wr_ready}, 64'd1);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (reqA || bus_valid) n++;
    end
    chk("t6_quiet", 64'(n), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
